// File: rtl/game_pkg.sv
// Shared types and constants for the pattern-guessing game controller.
// Holds the sequencer state encoding visible on the phase output.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        PLAY    = 3'd2,
        GRADING = 3'd3,
        WON     = 3'd4,
        LOST    = 3'd5
    } state_t;

    localparam int         NUM_SLOTS  = 4;
    localparam logic [3:0] WIN_ZNARLY = 4'd4;

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down game-credit counter; simultaneous inc and dec cancel.
// A dec at zero is absorbed so the count never wraps.
module credit_counter #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         nonzero
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !dec) begin
            if (count != MAX_V)
                count <= count + W'(1);
        end else if (dec && !inc) begin
            if (count != '0)
                count <= count - W'(1);
        end
    end

    assign nonzero = (count != '0);

endmodule

// File: rtl/game_sequencer.sv
// Game controller: credits, pattern load, guess rounds and win/lose outcome.
// Optional feature: define GAME_SEQ_FORFEIT_EN to let startGame forfeit a running game.
module game_sequencer
    import game_pkg::*;
#(
    parameter int MAX_ROUNDS  = 8,
    parameter int MAX_CREDITS = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       creditAdd,
    input  logic       startGame,
    input  logic       loadShapeNow,
    input  logic [1:0] shapeLocation,
    input  logic       gradeIt,
    input  logic       gradeDone,
    input  logic [3:0] znarly,
    output logic       loadEn,
    output logic       gradeEn,
    output logic       clearGame,
    output logic [3:0] numGames,
    output logic [3:0] roundNumber,
    output logic [3:0] slotMask,
    output logic       gameWon,
    output logic       gameLost,
    output logic [2:0] phase
);

`ifdef GAME_SEQ_FORFEIT_EN
    localparam bit FORFEIT = 1'b1;
`else
    localparam bit FORFEIT = 1'b0;
`endif

    localparam logic [3:0]           LAST_ROUND = 4'(MAX_ROUNDS);
    localparam logic [NUM_SLOTS-1:0] ALL_SLOTS  = '1;

    state_t               state, state_n;
    logic                 load_n, grade_n, clear_n;
    logic [3:0]           round_n;
    logic [NUM_SLOTS-1:0] mask_n, mask_upd;
    logic                 won_n, lost_n;
    logic                 consume;
    logic                 credit_nz;

    credit_counter #(
        .MAX (MAX_CREDITS),
        .W   (4)
    ) u_credits (
        .clock   (clock),
        .reset   (reset),
        .inc     (creditAdd),
        .dec     (consume),
        .count   (numGames),
        .nonzero (credit_nz)
    );

    assign mask_upd = slotMask | (NUM_SLOTS'(1) << shapeLocation);

    always_comb begin
        state_n = state;
        load_n  = 1'b0;
        grade_n = 1'b0;
        clear_n = 1'b0;
        round_n = roundNumber;
        mask_n  = slotMask;
        won_n   = gameWon;
        lost_n  = gameLost;
        consume = 1'b0;
        unique case (state)
            IDLE, WON, LOST: begin
                if (startGame && credit_nz) begin
                    state_n = LOAD;
                    consume = 1'b1;
                    clear_n = 1'b1;
                    round_n = '0;
                    mask_n  = '0;
                    won_n   = 1'b0;
                    lost_n  = 1'b0;
                end else if (startGame && state != IDLE) begin
                    // Out of credits after a finished game: drop back to attract mode
                    state_n = IDLE;
                    won_n   = 1'b0;
                    lost_n  = 1'b0;
                end
            end
            LOAD: begin
                if (FORFEIT && startGame) begin
                    state_n = LOST;
                    lost_n  = 1'b1;
                end else if (loadShapeNow) begin
                    load_n = 1'b1;
                    mask_n = mask_upd;
                    if (mask_upd == ALL_SLOTS)
                        state_n = PLAY;
                end
            end
            PLAY: begin
                if (FORFEIT && startGame) begin
                    state_n = LOST;
                    lost_n  = 1'b1;
                end else if (gradeIt) begin
                    grade_n = 1'b1;
                    round_n = roundNumber + 4'd1;
                    state_n = GRADING;
                end
            end
            GRADING: begin
                if (FORFEIT && startGame) begin
                    state_n = LOST;
                    lost_n  = 1'b1;
                end else if (gradeDone) begin
                    if (znarly == WIN_ZNARLY) begin
                        state_n = WON;
                        won_n   = 1'b1;
                    end else if (roundNumber == LAST_ROUND) begin
                        state_n = LOST;
                        lost_n  = 1'b1;
                    end else begin
                        state_n = PLAY;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            loadEn      <= 1'b0;
            gradeEn     <= 1'b0;
            clearGame   <= 1'b0;
            roundNumber <= '0;
            slotMask    <= '0;
            gameWon     <= 1'b0;
            gameLost    <= 1'b0;
        end else begin
            state       <= state_n;
            loadEn      <= load_n;
            gradeEn     <= grade_n;
            clearGame   <= clear_n;
            roundNumber <= round_n;
            slotMask    <= mask_n;
            gameWon     <= won_n;
            gameLost    <= lost_n;
        end
    end

    assign phase = state;

endmodule
